// File: rtl/wave_pkg.sv
// Shared types and constants for the wave measurement sequencer and its
// settle detector.
package wave_pkg;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLEAR   = 2'd1,
        MEASURE = 2'd2,
        REPORT  = 2'd3
    } seq_state_t;

    localparam int FREQ_W = 22;
    localparam int AMP_W  = 12;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

    // A sample only counts toward settling if it repeats the previous one
    // and is nonzero; a zero period count means no crossing seen yet.
    function automatic logic freq_unchanged(
        input logic [FREQ_W-1:0] cur,
        input logic [FREQ_W-1:0] prev
    );
        return (cur == prev) && (cur != {FREQ_W{1'b0}});
    endfunction

endpackage

// File: rtl/wave_settle_detect.sv
// Watches the analyzer frequency count and flags when it has held the same
// nonzero value for STABLE_CYCLES consecutive comparisons.
module wave_settle_detect
    import wave_pkg::*;
#(
    parameter int STABLE_CYCLES = 1024
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [FREQ_W-1:0] sample,
    output logic              done
);

    localparam int               CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] DONE_CNT = CNT_W'(STABLE_CYCLES - 1);

    logic [FREQ_W-1:0] prev_freq_r;
    logic [CNT_W-1:0]  stable_cnt_r;
    logic              match_s;

    // Compare the current sample against the one seen last cycle.
    always_comb begin
        match_s = freq_unchanged(sample, prev_freq_r);
    end

    // Done fires on the comparison that completes the required run.
    always_comb begin
        done = match_s && (stable_cnt_r == DONE_CNT);
    end

    // History register and saturating run-length counter; cleared while
    // the sequencer is not measuring so each window starts from zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_freq_r  <= {FREQ_W{1'b0}};
            stable_cnt_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            prev_freq_r  <= {FREQ_W{1'b0}};
            stable_cnt_r <= {CNT_W{1'b0}};
        end else begin
            prev_freq_r <= sample;
            if (match_s) begin
                if (stable_cnt_r != CNT_MAX) begin
                    stable_cnt_r <= stable_cnt_r + CNT_W'(1);
                end else begin
                    stable_cnt_r <= stable_cnt_r;
                end
            end else begin
                stable_cnt_r <= {CNT_W{1'b0}};
            end
        end
    end

endmodule

// File: rtl/wave_measure_sequencer.sv
// Sequences the wave analyzer through clear / measure / report windows and
// offers each latched frequency/amplitude result on a valid/ready handshake.
module wave_measure_sequencer
    import wave_pkg::*;
#(
    parameter int CLR_CYCLES    = 2,
    parameter int STABLE_CYCLES = 1024,
    parameter int WINDOW_CYCLES = 2000000,
    parameter bit ALTERNATE     = 1'b1
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              continuous,
    input  logic [FREQ_W-1:0] ana_freq,
    input  logic [AMP_W-1:0]  ana_amp,
    output logic              ana_clr,
    output logic              ch_sel,
    output logic              busy,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [FREQ_W-1:0] res_freq,
    output logic [AMP_W-1:0]  res_amp,
    output logic              res_ch,
    output logic              res_timeout
);

    localparam int                CLR_W    = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [CLR_W-1:0]  CLR_LAST = CLR_W'(CLR_CYCLES - 1);
    localparam logic [FREQ_W-1:0] WIN_LAST = FREQ_W'(WINDOW_CYCLES - 1);

    seq_state_t        state_r;
    seq_state_t        next_state_s;
    logic [CLR_W-1:0]  clr_cnt_r;
    logic [FREQ_W-1:0] win_cnt_r;
    logic              done_s;
    logic              timeout_s;
    logic              finish_s;
    logic              handshake_s;
    logic              settle_clear_s;

    // The settle detector only accumulates history while measuring.
    always_comb begin
        settle_clear_s = (state_r != MEASURE);
    end

    wave_settle_detect #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_settle (
        .clk    (clk),
        .reset  (reset),
        .clear  (settle_clear_s),
        .sample (ana_freq),
        .done   (done_s)
    );

    // Next-state logic plus the per-state qualifiers used by the datapath.
    always_comb begin
        next_state_s = state_r;
        timeout_s    = 1'b0;
        finish_s     = 1'b0;
        handshake_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start || continuous) begin
                    next_state_s = CLEAR;
                end else begin
                    next_state_s = IDLE;
                end
            end
            CLEAR: begin
                if (clr_cnt_r == CLR_LAST) begin
                    next_state_s = MEASURE;
                end else begin
                    next_state_s = CLEAR;
                end
            end
            MEASURE: begin
                timeout_s = (win_cnt_r == WIN_LAST);
                finish_s  = done_s || timeout_s;
                if (finish_s) begin
                    next_state_s = REPORT;
                end else begin
                    next_state_s = MEASURE;
                end
            end
            REPORT: begin
                handshake_s = res_valid && res_ready;
                if (handshake_s) begin
                    if (continuous) begin
                        next_state_s = CLEAR;
                    end else begin
                        next_state_s = IDLE;
                    end
                end else begin
                    next_state_s = REPORT;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register and the clear / window counters, which restart from
    // zero on every entry into their state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            clr_cnt_r <= {CLR_W{1'b0}};
            win_cnt_r <= {FREQ_W{1'b0}};
        end else begin
            state_r <= next_state_s;
            if ((state_r == CLEAR) && (next_state_s == CLEAR)) begin
                clr_cnt_r <= clr_cnt_r + CLR_W'(1);
            end else begin
                clr_cnt_r <= {CLR_W{1'b0}};
            end
            if ((state_r == MEASURE) && (next_state_s == MEASURE)) begin
                win_cnt_r <= win_cnt_r + FREQ_W'(1);
            end else begin
                win_cnt_r <= {FREQ_W{1'b0}};
            end
        end
    end

    // Registered control outputs, decoded from the state being entered so
    // they line up with the state itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            ana_clr   <= 1'b0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            ch_sel    <= CH_LEFT;
        end else begin
            ana_clr   <= (next_state_s == CLEAR);
            busy      <= (next_state_s != IDLE);
            res_valid <= (next_state_s == REPORT);
            if (handshake_s && ALTERNATE) begin
                ch_sel <= ~ch_sel;
            end else begin
                ch_sel <= ch_sel;
            end
        end
    end

    // Result register: captured once at the end of a window and held
    // (including through IDLE) until the next window finishes.
    always_ff @(posedge clk) begin
        if (reset) begin
            res_freq    <= {FREQ_W{1'b0}};
            res_amp     <= {AMP_W{1'b0}};
            res_ch      <= CH_LEFT;
            res_timeout <= 1'b0;
        end else if (finish_s) begin
            res_freq    <= ana_freq;
            res_amp     <= ana_amp;
            res_ch      <= ch_sel;
            res_timeout <= timeout_s && !done_s;
        end else begin
            res_freq    <= res_freq;
            res_amp     <= res_amp;
            res_ch      <= res_ch;
            res_timeout <= res_timeout;
        end
    end

endmodule

// File: tb/tb_wave_measure_sequencer.sv
// Directed + randomized bench for wave_measure_sequencer. Each window's
// expected outcome is computed from the whole sample sequence fed in.
module tb_wave_measure_sequencer;

    localparam int CLR = 2;
    localparam int STB = 8;
    localparam int WIN = 200;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        continuous;
    logic [21:0] ana_freq;
    logic [11:0] ana_amp;
    logic        ana_clr;
    logic        ch_sel;
    logic        busy;
    logic        res_valid;
    logic        res_ready;
    logic [21:0] res_freq;
    logic [11:0] res_amp;
    logic        res_ch;
    logic        res_timeout;

    int checks = 0;
    int errors = 0;

    logic [21:0] fseq [WIN];
    logic [11:0] aseq [WIN];
    logic        exp_ch;
    int          exp_t;
    logic        exp_done;
    logic [21:0] hold_freq;
    logic [11:0] hold_amp;

    always #5 clk = ~clk;

    wave_measure_sequencer #(
        .CLR_CYCLES    (CLR),
        .STABLE_CYCLES (STB),
        .WINDOW_CYCLES (WIN),
        .ALTERNATE     (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .continuous  (continuous),
        .ana_freq    (ana_freq),
        .ana_amp     (ana_amp),
        .ana_clr     (ana_clr),
        .ch_sel      (ch_sel),
        .busy        (busy),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_freq    (res_freq),
        .res_amp     (res_amp),
        .res_ch      (res_ch),
        .res_timeout (res_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Build one window's sample sequence.
    task automatic gen(input int mode);
        int unsigned base;
        int unsigned len;
        base = $urandom_range(1, 100000);
        len  = $urandom_range(0, 150);
        for (int i = 0; i < WIN; i++) begin
            aseq[i] = 12'($urandom);
            case (mode)
                0: begin fseq[i] = (i < 50) ? 22'(i + 1) : 22'd50; aseq[i] = 12'd300; end
                1: fseq[i] = 22'(base + i);
                2: fseq[i] = 22'd0;
                3: fseq[i] = (i < len) ? 22'(base + i) : 22'(base + len + 7);
                4: fseq[i] = 22'(100 + i / STB);
                5: fseq[i] = (i < WIN - STB - 1) ? 22'(i + 1) : 22'd500;
                6: fseq[i] = (i < WIN - STB) ? 22'(i + 1) : 22'd500;
                default: fseq[i] = 22'd0;
            endcase
        end
    endtask

    // Window outcome: done at the first sample that ends a run of STB+1
    // equal nonzero samples, otherwise timeout at the last window cycle.
    task automatic model();
        exp_done = 1'b0;
        exp_t    = WIN - 1;
        for (int i = STB; i < WIN; i++) begin
            bit eq;
            eq = (fseq[i] != 22'd0);
            for (int k = i - STB; k < i; k++) begin
                if (fseq[k] != fseq[i]) eq = 1'b0;
            end
            if (eq) begin
                exp_done = 1'b1;
                exp_t    = i;
                break;
            end
        end
    endtask

    // Runs one window; the caller has set up the edge that enters CLEAR.
    task automatic measure(input string tag);
        model();
        @(posedge clk); #1;
        start     = 1'b0;
        res_ready = 1'b0;
        chk({tag, "_clr_a"}, 32'(ana_clr), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_chsel"}, 32'(ch_sel), 32'(exp_ch));
        chk({tag, "_valid_clr"}, 32'(res_valid), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_clr_b"}, 32'(ana_clr), 32'd1);
        @(posedge clk); #1;
        chk({tag, "_clr_end"}, 32'(ana_clr), 32'd0);
        ana_freq = fseq[0];
        ana_amp  = aseq[0];
        for (int i = 0; i < exp_t; i++) begin
            @(posedge clk); #1;
            chk({tag, "_valid_early"}, 32'(res_valid), 32'd0);
            ana_freq = fseq[i + 1];
            ana_amp  = aseq[i + 1];
        end
        @(posedge clk); #1;
        chk({tag, "_valid"}, 32'(res_valid), 32'd1);
        chk({tag, "_freq"}, 32'(res_freq), 32'(fseq[exp_t]));
        chk({tag, "_amp"}, 32'(res_amp), 32'(aseq[exp_t]));
        chk({tag, "_ch"}, 32'(res_ch), 32'(exp_ch));
        chk({tag, "_timeout"}, 32'(res_timeout), 32'(!exp_done));
        chk({tag, "_clr_rep"}, 32'(ana_clr), 32'd0);
    endtask

    // Accept the pending result with continuous low; returns to IDLE.
    task automatic accept_idle(input string tag);
        logic [21:0] f;
        f = res_freq;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        exp_ch    = ~exp_ch;
        chk({tag, "_acc_valid"}, 32'(res_valid), 32'd0);
        chk({tag, "_acc_busy"}, 32'(busy), 32'd0);
        chk({tag, "_acc_chsel"}, 32'(ch_sel), 32'(exp_ch));
        @(posedge clk); #1;
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_idle_hold"}, 32'(res_freq), 32'(f));
    endtask

    task automatic run_single(input int mode, input string tag);
        gen(mode);
        start = 1'b1;
        measure(tag);
        accept_idle(tag);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_clr"}, 32'(ana_clr), 32'd0);
        chk({tag, "_chsel"}, 32'(ch_sel), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_valid"}, 32'(res_valid), 32'd0);
        chk({tag, "_freq"}, 32'(res_freq), 32'd0);
        chk({tag, "_amp"}, 32'(res_amp), 32'd0);
        chk({tag, "_ch"}, 32'(res_ch), 32'd0);
        chk({tag, "_to"}, 32'(res_timeout), 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        continuous = 1'b0;
        res_ready  = 1'b0;
        ana_freq   = 22'd0;
        ana_amp    = 12'd0;
        exp_ch     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        @(posedge clk); #1;
        chk("idle_stays", 32'(busy), 32'd0);

        // Settling ramp, steady increment, stuck-at-zero.
        run_single(0, "ramp");
        run_single(1, "incr");
        run_single(2, "zero");
        // Boundaries: done on the last window cycle, one cycle too late,
        // runs that repeatedly fall one short.
        run_single(5, "done_last");
        run_single(6, "late_settle");
        run_single(4, "short_runs");
        for (int r = 0; r < 2; r++) begin
            run_single(3, "rand");
        end

        // Back-to-back windows in continuous mode.
        gen(3);
        continuous = 1'b1;
        start      = 1'b1;
        measure("cont0");
        for (int r = 1; r < 3; r++) begin
            gen(3);
            exp_ch    = ~exp_ch;
            res_ready = 1'b1;
            measure("cont");
        end
        continuous = 1'b0;
        accept_idle("cont_end");

        // Backpressure: result stays put, start ignored.
        gen(3);
        start = 1'b1;
        measure("bp");
        hold_freq = res_freq;
        hold_amp  = res_amp;
        for (int c = 0; c < 20; c++) begin
            ana_freq = 22'($urandom);
            ana_amp  = 12'($urandom);
            start    = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            chk("bp_valid", 32'(res_valid), 32'd1);
            chk("bp_freq", 32'(res_freq), 32'(hold_freq));
            chk("bp_amp", 32'(res_amp), 32'(hold_amp));
            chk("bp_clr", 32'(ana_clr), 32'd0);
        end
        start = 1'b0;
        accept_idle("bp");

        // One more window so the channel select is on the right channel.
        run_single(3, "pre_rst");
        chk("pre_rst_ch1", 32'(ch_sel), 32'd1);

        // Reset mid-MEASURE.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ana_freq = 22'd77;
        repeat (8) @(posedge clk);
        #1;
        chk("mid_meas_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset  = 1'b0;
        exp_ch = 1'b0;
        check_all_zero("rst_meas");
        @(posedge clk); #1;
        chk("rst_meas_idle", 32'(busy), 32'd0);

        // Reset mid-REPORT, then a normal run.
        gen(0);
        start = 1'b1;
        measure("pre_rep");
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_all_zero("rst_rep");
        run_single(3, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
